// File: rtl/trace_recorder.sv
// trace_recorder: stamps probe samples into a record FIFO and streams them out, closing each capture with an end record; define TRACE_RECORDER_DEDUP_EN to suppress repeated samples
module trace_recorder #(
  parameter int DATA_W = 64,
  parameter int CYC_W  = 40,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     probe_valid,
  input  logic [DATA_W-1:0]        probe_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYC_W+DATA_W:0]    out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 1 + CYC_W + DATA_W;
  typedef enum logic [2:0] {IDLE, RECORD, DRAIN, EOT, DONE} state_t;
  state_t state, state_n;
  logic [CYC_W-1:0] cyc;
  logic [AW-1:0] rd_ptr, wr_ptr, rd_n;
  logic [AW:0] count, count_n;
  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] head_n;
  logic launch, want, full, push, drop, pop;
  assign launch = start && (state == IDLE || state == DONE);
`ifdef TRACE_RECORDER_DEDUP_EN
  logic [DATA_W-1:0] last;
  logic have_last;
  assign want = probe_valid && (!have_last || probe_data != last);
  // last accepted sample of this capture; a dropped sample never becomes the reference
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      last <= '0;
      have_last <= 1'b0;
    end else if (launch) begin
      last <= '0;
      have_last <= 1'b0;
    end else if (push) begin
      last <= probe_data;
      have_last <= 1'b1;
    end
`else
  assign want = probe_valid;
`endif
  // fullness is judged before the same-cycle pop, so a full FIFO drops even while draining
  assign full    = count == (AW+1)'(DEPTH);
  assign push    = state == RECORD && want && !full;
  assign drop    = state == RECORD && want && full;
  assign pop     = out_valid && out_ready && state != EOT;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_n    = rd_ptr + AW'(pop);
  // the next head bypasses the memory when this cycle's push lands in an empty FIFO
  assign head_n  = count == (AW+1)'(pop) ? {1'b0, cyc, probe_data} : mem[rd_n];
  // capture sequencing: DRAIN waits until the FIFO and output stage are empty
  always_comb begin
    state_n = state;
    if (launch) state_n = RECORD;
    else if (state == RECORD && stop) state_n = DRAIN;
    else if (state == DRAIN && count == '0 && !out_valid) state_n = EOT;
    else if (state == EOT && out_valid && out_ready) state_n = DONE;
  end
  // record storage written at the tail
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {1'b0, cyc, probe_data};
  // state, counters, flags and the output stage that mirrors the FIFO head
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      cyc        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      busy       <= state_n inside {RECORD, DRAIN, EOT};
      done       <= state_n == DONE;
      cyc        <= launch ? '0 : state == RECORD ? cyc + CYC_W'(1) : cyc;
      rd_ptr     <= rd_n;
      wr_ptr     <= wr_ptr + AW'(push);
      count      <= count_n;
      overflow   <= launch ? 1'b0 : overflow || drop;
      drop_count <= launch ? '0 : (drop && drop_count != '1) ? drop_count + DROP_W'(1) : drop_count;
      out_valid  <= state_n == EOT || count_n != '0;
      out_data   <= state_n == EOT ? {1'b1, cyc, DATA_W'(drop_count)} : count_n != '0 ? head_n : '0;
    end
endmodule

// File: tb/tb_trace_recorder.sv
// tb_trace_recorder: directed capture scenarios with hand-computed records
module tb_trace_recorder;
  localparam int DATA_W = 64;
  localparam int CYC_W  = 40;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;
  localparam int REC_W  = 1 + CYC_W + DATA_W;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic probe_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DATA_W-1:0] probe_data = '0;
  logic out_valid, busy, done, overflow;
  logic [REC_W-1:0] out_data;
  logic [DROP_W-1:0] drop_count;
  logic [REC_W-1:0] got_q [$];
  logic [REC_W-1:0] held = '0;
  logic stalled = 1'b0;
  logic [3:0] pat = 4'b1001;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  trace_recorder #(.DATA_W(DATA_W), .CYC_W(CYC_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .probe_valid(probe_valid), .probe_data(probe_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input bit k, input longint c, input longint d);
    return {k, CYC_W'(c), DATA_W'(d)};
  endfunction

  // handshakes are collected and stalls checked between edges, when inputs are settled
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) got_q.push_back(out_data);
    if (reset && stalled) check("stall_hold", {out_valid, out_data}, {1'b1, held});
    stalled = reset && out_valid && !out_ready;
    held = out_data;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch_capture();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic samples(input int n, input longint base);
    for (int i = 0; i < n; i++) begin
      probe_valid = 1'b1;
      probe_data = DATA_W'(base + i);
      stop = (i == n - 1);
      tick();
    end
    probe_valid = 1'b0;
    stop = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic expect_rec(input string tag, input logic [REC_W-1:0] exp);
    logic [REC_W-1:0] r;
    r = got_q.size() != 0 ? got_q.pop_front() : '1;
    check(tag, r, exp);
  endtask

  initial begin
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);
    reset = 1'b1;
    tick();

    // basic three-sample capture, stop with the last sample
    out_ready = 1'b1;
    got_q.delete();
    launch_capture();
    check("t1_busy", busy, 1);
    probe_valid = 1'b1;
    probe_data = 'hA;
    tick();
    check("t1_lat_valid", out_valid, 1);
    check("t1_lat_data", out_data, mk(0, 0, 'hA));
    probe_data = 'hB;
    tick();
    probe_data = 'hC;
    stop = 1'b1;
    tick();
    probe_valid = 1'b0;
    stop = 1'b0;
    wait_done("t1", 30);
    expect_rec("t1_r0", mk(0, 0, 'hA));
    expect_rec("t1_r1", mk(0, 1, 'hB));
    expect_rec("t1_r2", mk(0, 2, 'hC));
    expect_rec("t1_end", mk(1, 3, 0));
    check("t1_extra", got_q.size(), 0);
    check("t1_busy_end", busy, 0);

    // overflow: 20 samples into 16 entries with the host stalled
    out_ready = 1'b0;
    got_q.delete();
    launch_capture();
    check("t2_done_fall", done, 0);
    samples(20, 0);
    check("t2_ovf", overflow, 1);
    check("t2_drop", drop_count, 4);
    out_ready = 1'b1;
    wait_done("t2", 80);
    for (int i = 0; i < 16; i++) expect_rec($sformatf("t2_r%0d", i), mk(0, i, i));
    expect_rec("t2_end", mk(1, 20, 4));
    check("t2_extra", got_q.size(), 0);

    // host ready pattern 1,0,0,1 while sampling
    got_q.delete();
    launch_capture();
    check("t3_ovf_clr", overflow, 0);
    check("t3_drop_clr", drop_count, 0);
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[i % 4];
      probe_valid = 1'b1;
      probe_data = DATA_W'(64'h10 + 64'(i));
      stop = (i == 4);
      tick();
    end
    probe_valid = 1'b0;
    stop = 1'b0;
    out_ready = 1'b1;
    wait_done("t3", 40);
    for (int i = 0; i < 5; i++) expect_rec($sformatf("t3_r%0d", i), mk(0, i, 'h10 + i));
    expect_rec("t3_end", mk(1, 5, 0));

    // stop and sample together at counter 7
    got_q.delete();
    launch_capture();
    for (int i = 0; i < 8; i++) begin
      probe_valid = (i == 7);
      stop = (i == 7);
      probe_data = 'h77;
      tick();
    end
    probe_valid = 1'b0;
    stop = 1'b0;
    wait_done("t4", 30);
    expect_rec("t4_r7", mk(0, 7, 'h77));
    expect_rec("t4_end", mk(1, 8, 0));

    // reset during DRAIN with five records queued
    out_ready = 1'b0;
    got_q.delete();
    launch_capture();
    samples(5, 'h30);
    check("t5_busy", busy, 1);
    check("t5_valid_pre", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_valid_rst", out_valid, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_data_rst", out_data, 0);
    tick();
    reset = 1'b1;
    got_q.delete();
    out_ready = 1'b1;
    tick();
    launch_capture();
    samples(1, 'h55);
    wait_done("t5", 30);
    expect_rec("t5_r0", mk(0, 0, 'h55));
    expect_rec("t5_end", mk(1, 1, 0));
    check("t5_drop", drop_count, 0);

`ifdef TRACE_RECORDER_DEDUP_EN
    // repeated values are suppressed without counting as drops
    got_q.delete();
    launch_capture();
    for (int i = 0; i < 5; i++) begin
      probe_valid = 1'b1;
      probe_data = (i == 2 || i == 3) ? 'h6 : 'h5;
      stop = (i == 4);
      tick();
    end
    probe_valid = 1'b0;
    stop = 1'b0;
    wait_done("t6", 30);
    expect_rec("t6_r0", mk(0, 0, 5));
    expect_rec("t6_r2", mk(0, 2, 6));
    expect_rec("t6_r4", mk(0, 4, 5));
    expect_rec("t6_end", mk(1, 5, 0));
    check("t6_drop", drop_count, 0);
    check("t6_ovf", overflow, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/trace_recorder.md
Name: trace_recorder

Overview:
- Capture end of the replay flow: records per-cycle probe samples from the DUT into a buffer and streams them out to the host as timestamped records.
- The host-side replay driver later turns these records back into stimulus.
- Sits between the probed DUT signals and the host transport, using a valid/ready stream.
- Start/stop controlled; a terminal end-of-trace record closes every capture.

Parameters:
- DATA_W, 64, probe sample width.
- CYC_W, 40, cycle-stamp width.
- DEPTH, 16, record FIFO entries; power of two, >=2.
- DROP_W, 16, dropped-sample counter width.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  pulse: begin a capture.
- stop  in  1  pulse: end the capture.
- probe_valid  in  1  sample present this cycle.
- probe_data  in  DATA_W  sample value.
- out_valid  out  1  record available.
- out_ready  in  1  host accepts the record.
- out_data  out  1+CYC_W+DATA_W  record {kind, cycle, payload}.
- busy  out  1  state is RECORD, DRAIN or EOT.
- done  out  1  capture finished, end record accepted.
- overflow  out  1  sticky: at least one sample dropped.
- drop_count  out  DROP_W  dropped samples, saturating.

Behaviour:
- Reset (reset=0, asynchronous), all of the following:
  - state=IDLE; FIFO empty.
  - out_valid=0, out_data=0.
  - busy=0, done=0, overflow=0, drop_count=0.
  - Cycle counter = 0.
- States: IDLE, RECORD, DRAIN, EOT, DONE.
- IDLE:
  - start -> RECORD next cycle; cycle counter, drop_count and overflow cleared.
  - stop is ignored; probes are ignored.
- RECORD:
  - Cycle counter increments by 1 every cycle and wraps modulo 2^CYC_W.
  - The first RECORD cycle has stamp 0.
  - probe_valid=1 pushes {0, counter, probe_data}; the stamp is the counter value in the sampling cycle.
  - start is ignored.
  - stop -> DRAIN next cycle; a sample in the stop cycle is still captured.
- Full FIFO:
  - Fullness is evaluated on occupancy before the same-cycle pop.
  - A push into a full FIFO is dropped even if a pop occurs that cycle.
  - On a drop: drop_count += 1, saturating at 2^DROP_W-1, and overflow is set.
- DRAIN:
  - No pushes; the counter is frozen.
  - When the FIFO is empty and no record is pending -> EOT.
- EOT:
  - Presents the end record {1, final counter, drop_count zero-extended to DATA_W}.
  - On handshake -> DONE.
- DONE:
  - done=1, busy=0.
  - start -> RECORD with counters and flags cleared; done falls.
- Output handshake:
  - A record transfers when out_valid && out_ready.
  - out_data is held stable while out_valid=1 && out_ready=0.
  - out_valid never drops without a handshake.
  - Output register is fed from the FIFO head.
  - A sample pushed into an empty FIFO with an empty output stage appears on out_valid in the next cycle (1-cycle latency).
  - Full throughput: 1 record/cycle when out_ready is held high.
- Records leave in capture order; the end record is always last and unique per capture.
- Reset mid-capture: everything is discarded immediately; no end record is emitted.

Optional Feature:
- Macro: TRACE_RECORDER_DEDUP_EN.
- Defined:
  - In RECORD, a valid sample is pushed only if probe_data differs from the last pushed sample of this capture.
  - The first sample of a capture is always pushed.
  - Suppressed samples neither count as drops nor set overflow.
  - The comparison register clears on start.
  - A dropped (FIFO-full) sample does not update the comparison register.
- Undefined: every valid sample in RECORD is pushed; no comparison logic is present.

Test Plan:
- Reset then start, then probe_valid=1 for 3 cycles with data 0xA,0xB,0xC, out_ready=1, then stop:
  - Records are {0,0,0xA}, {0,1,0xB}, {0,2,0xC}, then {1,3,0}.
  - done=1 after the final handshake.
- out_ready=0, start, 20 consecutive samples, stop, then out_ready=1:
  - 16 data records are delivered with stamps 0..15.
  - The end record payload is 4; overflow=1.
- out_ready toggling 1,0,0,1 during 5 samples:
  - out_data is stable in every stall cycle.
  - No loss or duplication; stamps are strictly increasing.
- stop and probe_valid together in the same cycle as counter=7:
  - A record with stamp 7 is emitted before the end record.
  - The end record cycle field is 8.
- reset asserted low during DRAIN with 5 records queued:
  - out_valid=0 immediately.
  - A subsequent start yields a fresh capture with stamp 0 and drop_count=0.
- DEDUP_EN, samples 5,5,6,6,5 on cycles 0-4:
  - Records are {0,0,5}, {0,2,6}, {0,4,5}; drop_count=0.
